harmonic_cfg_seq: RTL
=====================

// Module: harmonic_cfg_seq
// PURPOSE
// - Sequences DDS configuration for the NUM_CH harmonic generators of the signal source.
// - On a request, computes harmonic phase increments k*cfg_freq (k=1..NUM_CH) by accumulation, with no multiplier.
// - Writes each channel's {phase, increment} word in order, one channel at a time, using a valid/ready handshake.
// - Holds the summed DA output muted until the DDS pipelines settle, then reports completion.
// PARAMETERS
// - NUM_CH      5   number of harmonic DDS channels (channel i carries harmonic i+1)
// - FW          32  phase-increment (frequency) word width
// - PW          32  phase-offset word width
// - SETTLE_CYC  16  cycles of DDS pipeline latency waited after the last write (>=1)
// PORTS
// - clk             in   1            DDS sample clock
// - rst_n           in   1            async reset, active low
// - cfg_req         in   1            1-cycle pulse: start new configuration
// - cfg_freq        in   FW           fundamental phase increment
// - cfg_phase       in   NUM_CH*PW    per-channel phase offsets, ch i at [i*PW +: PW]
// - dds_cfg_tvalid  out  NUM_CH       one-hot per-channel config valid
// - dds_cfg_tdata   out  PW+FW        shared config word {phase, increment}
// - dds_cfg_tready  in   NUM_CH       per-channel config ready
// - cfg_busy        out  1            sequence in progress
// - cfg_done        out  1            1-cycle pulse: sequence complete
// - mute            out  1            force DA sum to 0 while high
// - err_ovf         out  NUM_CH       sticky per-channel Nyquist overflow flags, cleared at the start of each sequence
// BEHAVIOUR
// - Reset: state=IDLE; tvalid=0, tdata=0, busy=0, done=0, mute=0, err_ovf=0, pending=0.
// - FSM states: IDLE -> SEND -> SETTLE -> IDLE.
// - IDLE, cfg_req=1 at edge t:
//   - latch cfg_freq and cfg_phase; inc<=cfg_freq (33-bit with carry); ch<=0; err_ovf<=0
//   - from t+1: busy=1, mute=1, tvalid[0]=1
// - SEND:
//   - tdata={phase[ch], inc_out}; exactly one tvalid bit high (bit ch)
//   - tvalid and tdata stay stable until tready[ch]=1
//   - on handshake edge: inc<=inc+freq; ch<=ch+1; the next channel's tvalid rises at the same edge (no bubble)
//   - after ch NUM_CH-1 handshakes: tvalid=0, go to SETTLE
//   - tready bits of non-selected channels are ignored
// - SETTLE:
//   - counter runs 0..SETTLE_CYC-1
//   - at the final count edge: done=1 for one cycle; busy=0, mute=0; go to IDLE
//   - if pending=1 at that point: done still pulses, then restart exactly as from IDLE using the latest latched inputs, with mute held high continuously
// - Latency with tready tied 1, NUM_CH=5, SETTLE_CYC=16: req at t -> ch k valid at t+1+k -> done at t+22.
// - cfg_req while busy:
//   - sets pending and re-latches cfg_freq/cfg_phase into a shadow set
//   - later requests overwrite the shadow; the last one wins
//   - the active sequence is not disturbed
// - cfg_req in the same cycle as done: treated as pending, so a restart follows.
// - Width rule: increments are computed in FW+1 bits; the carry is sticky across accumulation (the value exceeds 2^FW).
// - Overflow condition: inc >= 2^(FW-1), or sticky carry.
// - rst_n asserted mid-sequence: all outputs return to reset values immediately (async); no done pulse; pending is lost.
// - cfg_freq=0: all increments are 0; the sequence completes normally.
// CONFIGURATION
// - HARMONIC_CFG_NYQ_CLAMP_EN defined:
//   - overflowing channel is written with increment 0 (phase still sent)
//   - that channel's err_ovf bit is set, sticky until the next sequence starts
// - HARMONIC_CFG_NYQ_CLAMP_EN undefined:
//   - increment written is inc mod 2^FW
//   - err_ovf tied 0
// TESTING
// - freq=0x0100_0000, phases 0, tready=1 -> tdata low words 0x0100_0000..0x0500_0000 on ch0..4; done at t+22; mute high t+1..t+21.
// - tready[2] held 0 for 7 cycles -> tvalid[2]/tdata stable for 8 cycles; later channel and done timings shift by 7; ch2 increment correct.
// - freq=0x2000_0000, clamp on -> ch3, ch4 increments 0; err_ovf=5'b11000. Clamp off -> 0x8000_0000, 0xA000_0000; err_ovf=0.
// - 2nd req (freq A) and 3rd req (freq B) during SEND -> one restart after done using freq B; mute never drops between sequences.
// - rst_n low during SETTLE -> busy/mute/tvalid=0 at once; no done; next req runs a clean sequence.
// - phase[i]=i*0x1111_1111 -> ch i tdata upper word equals i*0x1111_1111.

Source files
------------

// File: rtl/harmonic_cfg_seq.sv
// harmonic_cfg_seq: writes {phase, k*freq} config words to NUM_CH harmonic DDS channels, then mutes until settled.
// Define HARMONIC_CFG_NYQ_CLAMP_EN to zero increments at/above Nyquist and flag them in err_ovf.
module harmonic_cfg_seq #(
  parameter int NUM_CH     = 5,
  parameter int FW         = 32,
  parameter int PW         = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_req,
  input  logic [FW-1:0]        cfg_freq,
  input  logic [NUM_CH*PW-1:0] cfg_phase,
  output logic [NUM_CH-1:0]    dds_cfg_tvalid,
  output logic [PW+FW-1:0]     dds_cfg_tdata,
  input  logic [NUM_CH-1:0]    dds_cfg_tready,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 mute,
  output logic [NUM_CH-1:0]    err_ovf
);
  localparam int CW = $clog2(NUM_CH + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SEND, SETTLE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] ch;
  logic [SW-1:0] cnt;
  logic [FW:0] inc, sum;
  logic [FW-1:0] freq, freq_sh, new_freq, inc_out;
  logic [NUM_CH*PW-1:0] phase, phase_sh, new_phase;
  logic pending, hs, last_ch, settled, start;
  always_comb begin
    hs        = state == SEND && dds_cfg_tready[ch];
    last_ch   = ch == CW'(NUM_CH - 1);
    settled   = state == SETTLE && cnt == SW'(SETTLE_CYC - 1);
    start     = ((state == IDLE || settled) && cfg_req) || (settled && pending);
    new_freq  = cfg_req ? cfg_freq : freq_sh;
    new_phase = cfg_req ? cfg_phase : phase_sh;
    sum       = inc + {1'b0, freq};
    state_nxt = start ? SEND : settled ? IDLE : (hs && last_ch) ? SETTLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // The carry bit is sticky: once a harmonic passes 2^FW, every higher one is over range too.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ch       <= '0;
      cnt      <= '0;
      inc      <= '0;
      freq     <= '0;
      phase    <= '0;
      freq_sh  <= '0;
      phase_sh <= '0;
      pending  <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= settled;
      if (start) begin
        freq    <= new_freq;
        phase   <= new_phase;
        inc     <= {1'b0, new_freq};
        ch      <= '0;
        pending <= 1'b0;
      end else begin
        if (cfg_req && state != IDLE) begin
          freq_sh  <= cfg_freq;
          phase_sh <= cfg_phase;
          pending  <= 1'b1;
        end
        if (hs) begin
          inc <= {inc[FW] | sum[FW], sum[FW-1:0]};
          ch  <= ch + 1'b1;
          cnt <= '0;
        end
        if (state == SETTLE) cnt <= cnt + 1'b1;
      end
    end
`ifdef HARMONIC_CFG_NYQ_CLAMP_EN
  logic ovf;
  assign ovf     = inc[FW] | inc[FW-1];
  assign inc_out = ovf ? '0 : inc[FW-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_ovf <= '0;
    else if (start) err_ovf <= '0;
    else if (hs && ovf) err_ovf[ch] <= 1'b1;
`else
  assign inc_out = inc[FW-1:0];
  assign err_ovf = '0;
`endif
  assign cfg_busy       = state != IDLE;
  assign mute           = cfg_busy;
  assign dds_cfg_tvalid = state == SEND ? NUM_CH'(1) << ch : '0;
  assign dds_cfg_tdata  = state == SEND ? {phase[ch*PW +: PW], inc_out} : '0;
endmodule
